axi_lite_ctrl_master: RTL and testbench
=======================================

Name: axi_lite_ctrl_master

Overview:
- AXI4-Lite initiator that turns single-word register commands into AXI-Lite write or read transactions.
- Counterpart to the accelerator's AXI-Lite register slave, which holds the {com, run} mode register at offset 0.
- Used in self-test and system benches, and by an on-chip sequencer to drive accelerator mode changes without the PS.
- One transaction in flight at a time; the response is returned on a valid/ready command-response port.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width. Fixed at 32; WSTRB is DATA_W/8 bits.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle (IDLE only).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address. Bits [1:0] are forced to 0 on issue.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- err_cnt  out  ERRCNT_W  saturating count of non-OKAY responses.
- M_AXI_AWADDR  out  ADDR_W;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DATA_W;  M_AXI_WSTRB  out  DATA_W/8;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1.
- M_AXI_ARADDR  out  ADDR_W;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  DATA_W;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1.

Behaviour:
- Reset (async assert, synchronous release): state = IDLE; all VALID/READY outputs, rsp_valid, rsp_rdata, rsp_resp, err_cnt, AWADDR, ARADDR, WDATA = 0. WSTRB is constant all-ones.
- All AXI outputs are registered and combinationally independent of AXI inputs.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid with cmd_write = 1: latch addr/data, assert AWVALID and WVALID next cycle, go to WADDR_DATA.
  - On cmd_valid with cmd_write = 0: latch addr, assert ARVALID, go to RADDR.
- WADDR_DATA:
  - Track aw_done and w_done independently. AWVALID drops the cycle after AWREADY is sampled high; WVALID likewise after WREADY.
  - The two handshakes complete in either order or in the same cycle.
  - When both are done, go to WRESP with BREADY = 1.
- WRESP: on BVALID & BREADY, capture BRESP into rsp_resp, set rsp_rdata = 0, drop BREADY, go to RESP.
- RADDR: hold ARVALID and ARADDR stable until ARREADY; then drop ARVALID, raise RREADY, go to RDATA.
- RDATA: on RVALID & RREADY, capture RDATA and RRESP, drop RREADY, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_resp are held stable until rsp_ready.
  - Then rsp_valid = 0 and the block returns to IDLE.
  - The next command is accepted no earlier than the cycle after the response handshake.
- Error counter: when the captured response is non-zero (SLVERR or DECERR), err_cnt increments by 1 in the RESP entry cycle. It saturates at all-ones; there is no wrap.
- Latency against a zero-wait slave: write cmd accept → rsp_valid = 4 cycles; read = 4 cycles.
- VALID is never withdrawn before its READY. Address and data never change while VALID is high.
- Any B or R beat arriving outside its wait state is ignored, since BREADY and RREADY are low then.
- Reset mid-transaction: all VALIDs deassert immediately (async), and any pending response is discarded. The slave is expected to be reset by the same reset.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package holds:
  - Response constants AXI_OKAY = 2'b00, AXI_EXOKAY = 2'b01, AXI_SLVERR = 2'b10, AXI_DECERR = 2'b11.
  - Master state encoding.
  - Accelerator register map constant REG_MODE = 0, with MODE_RUN = 2'b01 and MODE_COM = 2'b10 in {com, run} order.
- No sub-module; a single FSM with two done flags is natural.

Test Plan:
- Write 0x00000001 to addr 0x0 against the accelerator slave → AW and W handshake in the same cycle; rsp_resp = 0; slave mode register = {com, run} = 01; rsp_valid exactly 4 cycles after cmd accept.
- Read addr 0x0 after that write → rsp_rdata[1:0] = 2'b01, rsp_resp = 0.
- Slave model asserts AWREADY 3 cycles before WREADY, then the reverse order → exactly one AW and one W handshake each; WDATA = 0xDEADBEEF stable throughout; BREADY rises only after both handshakes complete.
- Slave returns BRESP = 2'b10 on three writes → rsp_resp = 2'b10 each time; err_cnt = 3. With ERRCNT_W = 2 and 5 errors → err_cnt = 3 (saturated).
- Hold rsp_ready low 10 cycles with a new cmd_valid pending → rsp data stable; cmd_ready = 0 throughout; the new command is accepted the cycle after the response handshake.
- Assert M_AXI_ARESETN low while ARVALID = 1 during a read of 0x4 → ARVALID = 0 in the same cycle (async); after release, state = IDLE and cmd_ready = 1 on the first clock.

Source files
------------

// File: rtl/axi_lite_ctrl_master_pkg.sv
// Shared definitions for the AXI-Lite control master: response codes, FSM
// encoding and the accelerator mode-register map.
package axi_lite_ctrl_master_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WADDR_DATA = 3'd1,
        ST_WRESP      = 3'd2,
        ST_RADDR      = 3'd3,
        ST_RDATA      = 3'd4,
        ST_RESP       = 3'd5
    } state_t;

    // Accelerator register map: {com, run} mode register at byte offset 0.
    localparam logic [31:0] REG_MODE = 32'h0000_0000;
    localparam logic [1:0]  MODE_RUN = 2'b01;
    localparam logic [1:0]  MODE_COM = 2'b10;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_ctrl_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one AXI
// write or read out, completion returned on a valid/ready response port.
module axi_lite_ctrl_master
    import axi_lite_ctrl_master_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ERRCNT_W-1:0]   err_cnt,

    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,

    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,

    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,

    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,

    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam logic [ADDR_W-1:0]   WORD_MASK = ~ADDR_W'(3);
    localparam logic [ERRCNT_W-1:0] ERR_MAX   = '1;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;

    // Only full-word writes are issued.
    assign M_AXI_WSTRB = '1;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_OKAY;
            err_cnt       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            M_AXI_AWADDR  <= cmd_addr & WORD_MASK;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WADDR_DATA;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr & WORD_MASK;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RADDR;
                        end
                    end
                end

                // AW and W complete independently, in either order.
                ST_WADDR_DATA: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WRESP;
                    end
                end

                ST_WRESP: begin
                    if (M_AXI_BVALID && M_AXI_BREADY) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_valid    <= 1'b1;
                        if (resp_is_err(M_AXI_BRESP) && err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + ERRCNT_W'(1);
                        end
                        state <= ST_RESP;
                    end
                end

                ST_RADDR: begin
                    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (M_AXI_RVALID && M_AXI_RREADY) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_valid    <= 1'b1;
                        if (resp_is_err(M_AXI_RRESP) && err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + ERRCNT_W'(1);
                        end
                        state <= ST_RESP;
                    end
                end

                // Response held until consumed; IDLE reopens one cycle later.
                ST_RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ctrl_master.sv
// Bench for axi_lite_ctrl_master: behavioural AXI-Lite register slave with
// programmable ready delays and responses, vector table, corner sequences
// and a randomized phase against a word-array reference model.
module tb_axi_lite_ctrl_master;
    import axi_lite_ctrl_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;

    logic        cmd_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    logic        s_cmd_ready, s_rsp_valid;
    logic [31:0] s_rsp_rdata, s_awaddr, s_wdata, s_araddr;
    logic [1:0]  s_rsp_resp;
    logic [1:0]  sat_err_cnt;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    axi_lite_ctrl_master u_dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Narrow-counter instance runs in lockstep on the same slave signals.
    axi_lite_ctrl_master #(.ERRCNT_W(2)) u_sat (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata),
        .rsp_resp(s_rsp_resp), .err_cnt(sat_err_cnt),
        .M_AXI_AWADDR(s_awaddr), .M_AXI_AWVALID(s_awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(s_wdata), .M_AXI_WSTRB(s_wstrb), .M_AXI_WVALID(s_wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(s_bready),
        .M_AXI_ARADDR(s_araddr), .M_AXI_ARVALID(s_arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(s_rready)
    );

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  slv_resp = AXI_OKAY;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_q = '0, w_q = '0;
    logic [31:0] smem [16];
    logic        aw_now, w_now;
    logic [31:0] addr_now, data_now;

    assign aw_now   = aw_got || (awvalid && awready);
    assign w_now    = w_got || (wvalid && wready);
    assign addr_now = aw_got ? aw_q : awaddr;
    assign data_now = w_got ? w_q : wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= '0; rresp <= '0; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            if (awvalid && !awready && !aw_got) begin
                if (aw_cnt >= aw_dly) awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && !wready && !w_got) begin
                if (w_cnt >= w_dly) wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (awvalid && awready) begin aw_got <= 1'b1; aw_q <= awaddr; aw_cnt <= 0; end
            if (wvalid && wready) begin w_got <= 1'b1; w_q <= wdata; w_cnt <= 0; end
            if (aw_now && w_now && !bvalid) begin
                bvalid <= 1'b1; bresp <= slv_resp; aw_got <= 1'b0; w_got <= 1'b0;
                if (slv_resp == AXI_OKAY)
                    smem[addr_now[5:2]] <= (addr_now[5:2] == 4'd0) ? {30'd0, data_now[1:0]} : data_now;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && !arready && !rvalid) begin
                if (ar_cnt >= ar_dly) arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1; rresp <= slv_resp; ar_cnt <= 0;
                rdata <= (slv_resp == AXI_OKAY) ? smem[araddr[5:2]] : '0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, viol = 0, bready_early = 0;
    longint      cyc = 0, aw_cyc = 0, w_cyc = 0;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic        p_bready = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
            p_bready <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
        end else begin
            if (awvalid && awready) begin aw_hs <= aw_hs + 1; aw_cyc <= cyc; aw_pend <= 1'b1; end
            if (wvalid && wready) begin w_hs <= w_hs + 1; w_cyc <= cyc; w_pend <= 1'b1; end
            if (arvalid && arready) ar_hs <= ar_hs + 1;
            if (bvalid && bready) begin aw_pend <= 1'b0; w_pend <= 1'b0; end
            if (bready && !p_bready && !(aw_pend && w_pend)) bready_early <= bready_early + 1;
            if ((p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) ||
                (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) ||
                (p_arv && !p_arr && (!arvalid || araddr != p_araddr)))
                viol <= viol + 1;
            p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
            p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata;
            p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
            p_bready <= bready;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_accept", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs,
                            output int lat, output int ec, output int sc);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("rsp_arrives", 64'(rsp_valid), 64'(1));
        rd = rsp_rdata; rs = rsp_resp; ec = int'(err_cnt); sc = int'(sat_err_cnt);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sresp;
        int          aw_dly;
        int          w_dly;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
        int          exp_err;
        int          exp_sat;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] mem_model [16];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat, ec, sc, aw0, w0, ar0, errs;

        // Table: aw_dly doubles as the AR delay on reads.
        vt[0]  = '{1'b1, 32'h0, 32'h1,        AXI_OKAY,   0, 0, 32'h0,        AXI_OKAY,   4, 0, 0};
        vt[1]  = '{1'b0, 32'h0, 32'h0,        AXI_OKAY,   0, 0, 32'h1,        AXI_OKAY,   4, 0, 0};
        vt[2]  = '{1'b1, 32'h8, 32'hDEADBEEF, AXI_OKAY,   0, 3, 32'h0,        AXI_OKAY,   7, 0, 0};
        vt[3]  = '{1'b1, 32'h8, 32'hDEADBEEF, AXI_OKAY,   3, 0, 32'h0,        AXI_OKAY,   7, 0, 0};
        vt[4]  = '{1'b0, 32'hB, 32'h0,        AXI_OKAY,   0, 0, 32'hDEADBEEF, AXI_OKAY,   4, 0, 0};
        vt[5]  = '{1'b1, 32'h0, 32'h2,        AXI_OKAY,   0, 0, 32'h0,        AXI_OKAY,   4, 0, 0};
        vt[6]  = '{1'b0, 32'h0, 32'h0,        AXI_OKAY,   0, 0, 32'h2,        AXI_OKAY,   4, 0, 0};
        vt[7]  = '{1'b1, 32'h4, 32'h5,        AXI_SLVERR, 0, 0, 32'h0,        AXI_SLVERR, 4, 1, 1};
        vt[8]  = '{1'b1, 32'h4, 32'h5,        AXI_SLVERR, 0, 0, 32'h0,        AXI_SLVERR, 4, 2, 2};
        vt[9]  = '{1'b1, 32'h4, 32'h5,        AXI_SLVERR, 0, 0, 32'h0,        AXI_SLVERR, 4, 3, 3};
        vt[10] = '{1'b0, 32'h4, 32'h0,        AXI_DECERR, 0, 0, 32'h0,        AXI_DECERR, 4, 4, 3};
        vt[11] = '{1'b1, 32'hC, 32'h7,        AXI_DECERR, 1, 1, 32'h0,        AXI_DECERR, 5, 5, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 64'(awvalid), 64'(0));
        chk("rst_wvalid", 64'(wvalid), 64'(0));
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_bready_rready", 64'({bready, rready}), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_resp}), 64'(0));
        chk("rst_err_cnt", 64'({err_cnt, sat_err_cnt}), 64'(0));
        chk("rst_addr_data", {awaddr, araddr} | 64'(wdata), 64'(0));
        chk("wstrb", 64'(wstrb), 64'(4'hF));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            aw_dly = vt[i].aw_dly; w_dly = vt[i].w_dly; ar_dly = vt[i].aw_dly;
            slv_resp = vt[i].sresp;
            aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
            issue(vt[i].write, vt[i].addr, vt[i].wdata);
            wait_rsp(rd, rs, lat, ec, sc);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].exp_rdata));
            chk($sformatf("vec%0d_resp", i), 64'(rs), 64'(vt[i].exp_resp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("vec%0d_err_cnt", i), 64'(ec), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_sat_err_cnt", i), 64'(sc), 64'(vt[i].exp_sat));
            chk($sformatf("vec%0d_aw_hs", i), 64'(aw_hs - aw0), 64'(vt[i].write ? 1 : 0));
            chk($sformatf("vec%0d_w_hs", i), 64'(w_hs - w0), 64'(vt[i].write ? 1 : 0));
            chk($sformatf("vec%0d_ar_hs", i), 64'(ar_hs - ar0), 64'(vt[i].write ? 0 : 1));
            if (vt[i].write)
                chk($sformatf("vec%0d_aw_w_same_cycle", i), 64'(aw_cyc == w_cyc),
                    64'(vt[i].aw_dly == vt[i].w_dly));
            if (vt[i].write && vt[i].addr == REG_MODE && vt[i].sresp == AXI_OKAY)
                chk($sformatf("vec%0d_mode_reg", i), 64'(smem[0][1:0]), 64'(vt[i].wdata[1:0]));
        end
        chk("mode_is_com", 64'(smem[0][1:0]), 64'(MODE_COM));

        // Response back-pressure with a new command pending
        aw_dly = 0; w_dly = 0; ar_dly = 0; slv_resp = AXI_OKAY;
        issue(1'b1, 32'h10, 32'h0000_1234);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("hold_rsp_arrives", 64'(rsp_valid), 64'(1));
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("hold_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'(0));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_idle_after_hs", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold_next_accepted", 64'({cmd_ready, arvalid}), 64'(2'b01));
        wait_rsp(rd, rs, lat, ec, sc);
        chk("hold_read_back", 64'(rd), 64'(32'h1234));

        // Reset while ARVALID is pending
        ar_dly = 6;
        issue(1'b0, 32'h4, 32'h0);
        chk("rst_mid_arvalid_up", 64'(arvalid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_arvalid_async", 64'(arvalid), 64'(0));
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rel_quiet", 64'({arvalid, rready, rsp_valid, err_cnt}), 64'(0));
        @(negedge clk);

        // Randomized phase against the word-array model
        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            bit          w;
            logic [31:0] a, d, exp_rd;
            logic [1:0]  sr;
            int unsigned r;
            int          exp_lat, idx;
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            r = $urandom_range(0, 7);
            sr = (r < 5) ? AXI_OKAY : 2'(r - 4);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            slv_resp = sr;
            idx = int'(a) / 4;
            if (w) begin
                exp_lat = 4 + ((aw_dly > w_dly) ? aw_dly : w_dly);
                exp_rd = '0;
                if (sr == AXI_OKAY) mem_model[idx] = (idx == 0) ? (d & 32'h3) : d;
            end else begin
                exp_lat = 4 + ar_dly;
                exp_rd = (sr == AXI_OKAY) ? mem_model[idx] : '0;
            end
            if (sr != AXI_OKAY) errs++;
            issue(w, a, d);
            wait_rsp(rd, rs, lat, ec, sc);
            chk($sformatf("rnd%0d_rdata", i), 64'(rd), 64'(exp_rd));
            chk($sformatf("rnd%0d_resp", i), 64'(rs), 64'(sr));
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat));
            chk($sformatf("rnd%0d_err_cnt", i), 64'(ec), 64'((errs > 255) ? 255 : errs));
            chk($sformatf("rnd%0d_sat_err_cnt", i), 64'(sc), 64'((errs > 3) ? 3 : errs));
        end

        chk("valid_stability", 64'(viol), 64'(0));
        chk("bready_after_both_hs", 64'(bready_early), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
